// File: rtl/mult_nxn_seq.sv
// Multi-cycle WIDTH x WIDTH multiplier built from CHUNK x CHUNK digit products.
// Operands are reduced to magnitudes at start. Only the significant digit pairs are
// visited, which skips leading zero digits. The sign is applied once in the FINISH cycle.
module mult_nxn_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned D  = WIDTH / CHUNK;
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 neg_q, neg_d;
  logic [IW-1:0]        na_q, na_d, nb_q, nb_d;  // index of top significant digit (NA-1, NB-1)
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [CHUNK-1:0]     dig_a, dig_b;
  logic [2*CHUNK-1:0]   pp;
  int unsigned          ia, ja;

  // Index of the highest nonzero digit; zero when the operand is zero.
  function automatic logic [IW-1:0] top_digit(input logic [WIDTH-1:0] x);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < int'(D); k++) begin
      if (x[k*CHUNK +: CHUNK] != '0) idx = IW'(k);
    end
    return idx;
  endfunction

  // Next-state logic: operand capture, digit-pair walk and result commit.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    na_d      = na_q;
    nb_d      = nb_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    product_d = product_q;
    done_d    = 1'b0;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
    mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;

    ia    = 32'(i_q);
    ja    = 32'(j_q);
    dig_a = a_q[CHUNK*ia +: CHUNK];
    dig_b = b_q[CHUNK*ja +: CHUNK];
    pp    = (2*CHUNK)'(dig_a) * (2*CHUNK)'(dig_b);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = mag_a;
          b_d     = mag_b;
          neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          na_d    = top_digit(mag_a);
          nb_d    = top_digit(mag_b);
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + ((2*WIDTH)'(pp) << (CHUNK * (ia + ja)));
        if (j_q == nb_q) begin
          j_d = '0;
          if (i_q == na_q) state_d = StFinish;
          else             i_d     = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StFinish: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      na_q      <= '0;
      nb_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      na_q      <= na_d;
      nb_q      <= nb_d;
      i_q       <= i_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // Outputs: busy follows the state directly so reset clears it without a clock edge.
  always_comb begin
    busy    = (state_q != StIdle);
    done    = done_q;
    product = product_q;
  end

endmodule

// File: tb/tb_mult_nxn_seq.sv
// Self-checking bench for mult_nxn_seq (WIDTH=32, CHUNK=8).
module tb_mult_nxn_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] last_prod;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] prod;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[8];

  mult_nxn_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic sm);
    longint px, py;
    if (sm) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
      return 64'(px * py);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic int ndig(input logic [31:0] x);
    int n;
    n = 1;
    for (int k = 0; k < 4; k++) if (((x >> (8 * k)) & 32'hFF) != 0) n = k + 1;
    return n;
  endfunction

  function automatic int ref_busy(input logic [31:0] x, input logic [31:0] y, input logic sm);
    logic [31:0] mx, my;
    mx = (sm && x[31]) ? (~x + 32'd1) : x;
    my = (sm && y[31]) ? (~y + 32'd1) : y;
    return ndig(mx) * ndig(my) + 1;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic sm);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; signed_mode = 1'($urandom_range(0, 1));
  endtask

  // Counts busy cycles, checks product holds, then checks the done cycle.
  task automatic finish_check(input int exp_busy, input logic [63:0] exp_prod,
                              input string name, input int poke_at);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      chk({name, "_hold"}, product, last_prod);
      if (cnt == poke_at) begin
        start = 1'b1; a = $urandom; b = $urandom; signed_mode = ~signed_mode;
      end else begin
        start = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_product"}, product, exp_prod);
    last_prod = exp_prod;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rsm;

    vecs[0] = '{32'd207223066, 32'd341312304, 1'b0, 64'd70727782098404064, 17};
    vecs[1] = '{32'h0000091A, 32'h00000330, 1'b0, 64'd1901280, 5};
    vecs[2] = '{32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFFFFFFFFEB, 2};
    vecs[3] = '{32'hFFFFFFFD, 32'd7, 1'b0, 64'h00000006FFFFFFEB, 5};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 17};
    vecs[5] = '{32'd0, 32'd5, 1'b0, 64'd0, 2};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, 2};
    vecs[7] = '{32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF80000000, 5};

    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    last_prod = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      launch(vecs[v].a, vecs[v].b, vecs[v].sm);
      finish_check(vecs[v].busy_cyc, vecs[v].prod, $sformatf("vec%0d", v), -1);
      idle_check($sformatf("vec%0d", v));
    end

    // Start re-pulsed mid-operation with other operands is ignored.
    launch(vecs[0].a, vecs[0].b, vecs[0].sm);
    finish_check(vecs[0].busy_cyc, vecs[0].prod, "ignored_start", 3);
    idle_check("ignored_start");

    // Start accepted in the done cycle.
    launch(vecs[1].a, vecs[1].b, vecs[1].sm);
    finish_check(vecs[1].busy_cyc, vecs[1].prod, "b2b_first", -1);
    launch(vecs[2].a, vecs[2].b, vecs[2].sm);
    chk("b2b_busy_rise", 64'(busy), 64'd1);
    finish_check(vecs[2].busy_cyc, vecs[2].prod, "b2b_second", -1);
    idle_check("b2b_second");

    // Asynchronous reset during RUN clears outputs without a clock edge.
    launch(vecs[0].a, vecs[0].b, vecs[0].sm);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_done", 64'(done), 64'd0);
    chk("async_reset_product", product, 64'd0);
    last_prod = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    launch(vecs[1].a, vecs[1].b, vecs[1].sm);
    finish_check(vecs[1].busy_cyc, vecs[1].prod, "after_reset", -1);
    idle_check("after_reset");

    // Randomized operands against the reference model.
    for (int r = 0; r < 30; r++) begin
      ra  = $urandom >> $urandom_range(0, 31);
      rb  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      rsm = 1'($urandom_range(0, 1));
      launch(ra, rb, rsm);
      finish_check(ref_busy(ra, rb, rsm), ref_prod(ra, rb, rsm), $sformatf("rand%0d", r), -1);
      if ($urandom_range(0, 1) == 0) idle_check($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
